int_ctrl: RTL and testbench

Interrupt controller for the two external interrupt channels, C and O, which feed the control unit. It detects rising edges on the request lines and keeps a pending flag, a mask and an in-service flag for each channel. It also holds the global interrupt-enable flag (IF) and produces the `c_shield_out`, `o_shield_out` and `IF_out` inputs that the control unit samples. In the same cycle it drives the interrupt vector for the control unit's `int_num` onto the vector bus, so the PC can load it.

---
 rtl/int_pkg.sv | 30 +++
 rtl/int_ctrl_if.sv | 37 +++
 rtl/int_chan.sv | 82 ++++++++
 rtl/int_ctrl.sv | 64 ++++++
 tb/tb_int_ctrl.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/int_pkg.sv
// int_pkg: shared definitions for the interrupt controller.
//   INT_NUM_C / INT_NUM_O : interrupt numbers used by the control unit for channels C and O.
//   VEC_BASE_DEFAULT      : default base address of the vector table.
//   VEC_STRIDE_DEFAULT    : default spacing of vector table entries in bytes.
//   chan_state_e          : per-channel state view derived from (pend, isr).
package int_pkg;

  localparam logic [2:0]  INT_NUM_C          = 3'd1;
  localparam logic [2:0]  INT_NUM_O          = 3'd2;
  localparam logic [7:0]  VEC_BASE_DEFAULT   = 8'hF0;
  localparam int unsigned VEC_STRIDE_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    SERVICE,
    SERVICE_PENDING
  } chan_state_e;

  // Map the two flags a channel actually stores onto the state view.
  function automatic chan_state_e chan_state(input logic pend, input logic isr);
    unique case ({isr, pend})
      2'b00:   return IDLE;
      2'b01:   return PENDING;
      2'b10:   return SERVICE;
      default: return SERVICE_PENDING;
    endcase
  endfunction

endpackage

// File: rtl/int_ctrl_if.sv
// int_ctrl_if: control-unit-facing bus of the interrupt controller.
//   master : drives requests, acknowledge/mask/IF controls and int_num; reads status and vector.
//   slave  : the interrupt controller itself.
interface int_ctrl_if;
  logic       c_req;
  logic       o_req;
  logic       IF_set;
  logic       IF_clear;
  logic       c_clear;
  logic       o_clear;
  logic       c_allow;
  logic       o_allow;
  logic       c_ban;
  logic       o_ban;
  logic       ovr_clr;
  logic [2:0] int_num;
  logic       c_shield_out;
  logic       o_shield_out;
  logic       IF_out;
  logic [7:0] vec_out;
  logic       c_isr;
  logic       o_isr;
  logic       c_ovr;
  logic       o_ovr;

  modport master (
    output c_req, o_req, IF_set, IF_clear, c_clear, o_clear, c_allow, o_allow,
           c_ban, o_ban, ovr_clr, int_num,
    input  c_shield_out, o_shield_out, IF_out, vec_out, c_isr, o_isr, c_ovr, o_ovr
  );

  modport slave (
    input  c_req, o_req, IF_set, IF_clear, c_clear, o_clear, c_allow, o_allow,
           c_ban, o_ban, ovr_clr, int_num,
    output c_shield_out, o_shield_out, IF_out, vec_out, c_isr, o_isr, c_ovr, o_ovr
  );
endinterface

// File: rtl/int_chan.sv
// int_chan: one interrupt channel (edge detect, pending, mask, in-service, overrun).
// Optional feature macro: INT_SYNC_EN adds a two-flop synchronizer (reset to 1) on req_i.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req_i         : request level; a 0->1 sample is an event
//   clear_i       : acknowledge (clear pending, enter in-service)
//   allow_i       : unmask and leave in-service
//   ban_i         : mask (wins over allow_i)
//   ovr_clr_i     : clear overrun (a simultaneous overrun wins)
//   shield_o      : pending and unmasked
//   isr_o, ovr_o  : in-service flag, sticky overrun flag
module int_chan (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  input  logic clear_i,
  input  logic allow_i,
  input  logic ban_i,
  input  logic ovr_clr_i,
  output logic shield_o,
  output logic isr_o,
  output logic ovr_o
);

  logic req_s;

`ifdef INT_SYNC_EN
  logic [1:0] sync_q;

  // Reset to 1 so a line held high through reset is not seen as an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], req_i};
    end
  end

  assign req_s = sync_q[1];
`else
  assign req_s = req_i;
`endif

  logic prev_q, prev_d;
  logic pend_q, pend_d;
  logic en_q, en_d;
  logic isr_q, isr_d;
  logic ovr_q, ovr_d;
  logic edge_ev;

  assign edge_ev = req_s & ~prev_q;

  always_comb begin
    prev_d = req_s;
    // A new event outranks a same-cycle acknowledge.
    pend_d = edge_ev | (pend_q & ~clear_i);
    // No overrun when the old request is acknowledged in the same cycle as the new one.
    ovr_d  = (edge_ev & pend_q & ~clear_i) | (ovr_q & ~ovr_clr_i);
    isr_d  = clear_i | (isr_q & ~allow_i);
    en_d   = ~ban_i & (allow_i | en_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b1;
      pend_q <= 1'b0;
      en_q   <= 1'b1;
      isr_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      pend_q <= pend_d;
      en_q   <= en_d;
      isr_q  <= isr_d;
      ovr_q  <= ovr_d;
    end
  end

  assign shield_o = pend_q & en_q;
  assign isr_o    = isr_q;
  assign ovr_o    = ovr_q;

endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: two-channel (C, O) interrupt controller for the control unit.
// Optional feature macro: INT_SYNC_EN (two-flop request synchronizers, 3-edge request latency).
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : int_ctrl_if.slave -- requests and controls in; shield, IF, vector, isr, ovr out
// Parameters: VEC_BASE (vector table base), VEC_STRIDE (entry spacing in bytes).
module int_ctrl
  import int_pkg::*;
#(
  parameter logic [7:0]  VEC_BASE   = VEC_BASE_DEFAULT,
  parameter int unsigned VEC_STRIDE = VEC_STRIDE_DEFAULT
) (
  input logic       clk,
  input logic       reset,
  int_ctrl_if.slave bus
);

  logic if_flag_q, if_flag_d;

  int_chan u_chan_c (
    .clk_i     (clk),
    .rst_ni    (reset),
    .req_i     (bus.c_req),
    .clear_i   (bus.c_clear),
    .allow_i   (bus.c_allow),
    .ban_i     (bus.c_ban),
    .ovr_clr_i (bus.ovr_clr),
    .shield_o  (bus.c_shield_out),
    .isr_o     (bus.c_isr),
    .ovr_o     (bus.c_ovr)
  );

  int_chan u_chan_o (
    .clk_i     (clk),
    .rst_ni    (reset),
    .req_i     (bus.o_req),
    .clear_i   (bus.o_clear),
    .allow_i   (bus.o_allow),
    .ban_i     (bus.o_ban),
    .ovr_clr_i (bus.ovr_clr),
    .shield_o  (bus.o_shield_out),
    .isr_o     (bus.o_isr),
    .ovr_o     (bus.o_ovr)
  );

  // Clear has priority over set.
  always_comb begin
    if_flag_d = ~bus.IF_clear & (bus.IF_set | if_flag_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_flag_q <= 1'b0;
    end else begin
      if_flag_q <= if_flag_d;
    end
  end

  assign bus.IF_out = if_flag_q;

  // Purely combinational: the PC loads this in the same cycle int_num is presented.
  assign bus.vec_out = 8'(32'(VEC_BASE) + 32'(bus.int_num) * VEC_STRIDE);

endmodule

// File: tb/tb_int_ctrl.sv
module tb_int_ctrl;
  import int_pkg::*;

`ifdef INT_SYNC_EN
  localparam int SyncLat = 2;
`else
  localparam int SyncLat = 0;
`endif

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  int_ctrl_if bus ();
  int_ctrl_if bus2 ();

  int_ctrl u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int_ctrl #(
    .VEC_BASE   (8'hFC),
    .VEC_STRIDE (2)
  ) u_dut_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  always #5 clk = ~clk;

  // Reference model: channel state view plus mask, overrun and request history.
  chan_state_e m_st  [2];
  bit          m_en  [2];
  bit          m_ovr [2];
  bit          m_prev[2];
  bit          m_s1  [2];
  bit          m_s2  [2];
  bit          m_if;

  function automatic bit is_pend(input chan_state_e s);
    return (s == PENDING) || (s == SERVICE_PENDING);
  endfunction

  function automatic bit in_svc(input chan_state_e s);
    return (s == SERVICE) || (s == SERVICE_PENDING);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int x = 0; x < 2; x++) begin
      m_st[x]   = IDLE;
      m_en[x]   = 1'b1;
      m_ovr[x]  = 1'b0;
      m_prev[x] = 1'b1;
      m_s1[x]   = 1'b1;
      m_s2[x]   = 1'b1;
    end
    m_if = 1'b0;
  endtask

  task automatic model_chan(input int x, input bit req, input bit clr, input bit alw,
                            input bit ban, input bit oclr);
    bit smp, ev, p, s;
    if (SyncLat != 0) begin
      smp     = m_s2[x];
      m_s2[x] = m_s1[x];
      m_s1[x] = req;
    end else begin
      smp = req;
    end
    ev        = smp && !m_prev[x];
    m_prev[x] = smp;
    p = is_pend(m_st[x]);
    s = in_svc(m_st[x]);
    if (ev && p && !clr) m_ovr[x] = 1'b1;
    else if (oclr)       m_ovr[x] = 1'b0;
    p = ev || (p && !clr);
    s = clr || (s && !alw);
    if (ban)      m_en[x] = 1'b0;
    else if (alw) m_en[x] = 1'b1;
    m_st[x] = chan_state(p, s);
  endtask

  task automatic model_update();
    if (!reset) begin
      model_reset();
    end else begin
      model_chan(0, bus.c_req, bus.c_clear, bus.c_allow, bus.c_ban, bus.ovr_clr);
      model_chan(1, bus.o_req, bus.o_clear, bus.o_allow, bus.o_ban, bus.ovr_clr);
      if (bus.IF_clear)    m_if = 1'b0;
      else if (bus.IF_set) m_if = 1'b1;
    end
  endtask

  task automatic compare_all(input string tag);
    int vec;
    vec = (240 + 2 * int'(bus.int_num)) % 256;
    check_eq({tag, ".c_shield"}, 32'(bus.c_shield_out), 32'(is_pend(m_st[0]) && m_en[0]));
    check_eq({tag, ".o_shield"}, 32'(bus.o_shield_out), 32'(is_pend(m_st[1]) && m_en[1]));
    check_eq({tag, ".if"},       32'(bus.IF_out), 32'(m_if));
    check_eq({tag, ".c_isr"},    32'(bus.c_isr), 32'(in_svc(m_st[0])));
    check_eq({tag, ".o_isr"},    32'(bus.o_isr), 32'(in_svc(m_st[1])));
    check_eq({tag, ".c_ovr"},    32'(bus.c_ovr), 32'(m_ovr[0]));
    check_eq({tag, ".o_ovr"},    32'(bus.o_ovr), 32'(m_ovr[1]));
    check_eq({tag, ".vec"},      32'(bus.vec_out), 32'(vec));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_update();
    #1;
    compare_all(tag);
  endtask

  task automatic idle_inputs();
    bus.IF_set   = 0; bus.IF_clear = 0;
    bus.c_clear  = 0; bus.o_clear  = 0;
    bus.c_allow  = 0; bus.o_allow  = 0;
    bus.c_ban    = 0; bus.o_ban    = 0;
    bus.ovr_clr  = 0;
  endtask

  initial begin
    clk = 0;
    reset = 0;
    errors = 0;
    checks = 0;
    bus.c_req = 0; bus.o_req = 0; bus.int_num = 0;
    idle_inputs();
    bus2.c_req = 0; bus2.o_req = 0; bus2.IF_set = 0; bus2.IF_clear = 0;
    bus2.c_clear = 0; bus2.o_clear = 0; bus2.c_allow = 0; bus2.o_allow = 0;
    bus2.c_ban = 0; bus2.o_ban = 0; bus2.ovr_clr = 0; bus2.int_num = 0;
    model_reset();
    #2;
    compare_all("rst");
    check_eq("rst_vec_base", 32'(bus.vec_out), 32'h0F0);
    repeat (2) step("rst_hold");
    reset = 1;
    step("rst_rel");

    // C request pulse with IF_set.
    bus.c_req = 1; bus.IF_set = 1;
    step("t1");
    bus.c_req = 0; bus.IF_set = 0;
    repeat (SyncLat) step("t1_lat");
    check_eq("t1_c_shield", 32'(bus.c_shield_out), 1);
    check_eq("t1_if", 32'(bus.IF_out), 1);
    check_eq("t1_o_shield", 32'(bus.o_shield_out), 0);

    // Acknowledge C while masking both; then unmask both.
    bus.c_clear = 1; bus.c_ban = 1; bus.o_ban = 1; bus.int_num = INT_NUM_C;
    step("t2");
    idle_inputs();
    check_eq("t2_c_shield", 32'(bus.c_shield_out), 0);
    check_eq("t2_c_isr", 32'(bus.c_isr), 1);
    check_eq("t2_vec", 32'(bus.vec_out), 32'h0F2);
    bus.c_allow = 1; bus.o_allow = 1;
    step("t2b");
    idle_inputs();
    check_eq("t2_c_isr_ret", 32'(bus.c_isr), 0);

    // Masked O still latches pending.
    bus.o_ban = 1;
    step("t3");
    idle_inputs();
    bus.o_req = 1;
    step("t3_req");
    bus.o_req = 0;
    repeat (SyncLat) step("t3_lat");
    check_eq("t3_o_masked", 32'(bus.o_shield_out), 0);
    bus.o_allow = 1;
    step("t3_allow");
    idle_inputs();
    check_eq("t3_o_unmasked", 32'(bus.o_shield_out), 1);

    // Overrun on C, clear it, then acknowledge coinciding with a new edge.
    bus.c_req = 1; step("t4a");
    bus.c_req = 0; step("t4b");
    bus.c_req = 1; step("t4c");
    bus.c_req = 0; step("t4d");
    repeat (SyncLat) step("t4_lat");
    check_eq("t4_c_ovr", 32'(bus.c_ovr), 1);
    bus.ovr_clr = 1;
    step("t4_oclr");
    idle_inputs();
    check_eq("t4_c_ovr_clr", 32'(bus.c_ovr), 0);
    bus.c_req = 1;
    repeat (SyncLat) step("t4_sync");
    bus.c_clear = 1;
    step("t4_race");
    idle_inputs();
    bus.c_req = 0;
    check_eq("t4_race_shield", 32'(bus.c_shield_out), 1);
    check_eq("t4_race_ovr", 32'(bus.c_ovr), 0);

    // Request held high through reset, IF set/clear clash, vector boundaries.
    bus.c_req = 1;
    reset = 0;
    #1;
    model_reset();
    repeat (2) step("t5_rst");
    reset = 1;
    repeat (4) step("t5_hold");
    check_eq("t5_no_pend", 32'(bus.c_shield_out), 0);
    bus.c_req = 0;
    bus.IF_set = 1; bus.IF_clear = 1;
    step("t5_if");
    idle_inputs();
    check_eq("t5_if_clr_wins", 32'(bus.IF_out), 0);
    bus.int_num = 3'd7;
    #1;
    check_eq("t5_vec7", 32'(bus.vec_out), 32'h0FE);
    bus2.int_num = 3'd4;
    #1;
    check_eq("t5_vec_wrap", 32'(bus2.vec_out), 32'h004);

    // Both channels in SERVICE_PENDING, then asynchronous reset.
    bus.IF_set = 1; bus.c_req = 1; bus.o_req = 1;
    step("t6a");
    idle_inputs();
    bus.c_req = 0; bus.o_req = 0;
    repeat (SyncLat) step("t6_lat");
    bus.c_clear = 1; bus.o_clear = 1;
    step("t6_ack");
    idle_inputs();
    bus.c_req = 1; bus.o_req = 1;
    step("t6b");
    bus.c_req = 0; bus.o_req = 0;
    repeat (SyncLat) step("t6_lat2");
    check_eq("t6_c_state", 32'(m_st[0]), 32'(SERVICE_PENDING));
    check_eq("t6_c_shield", 32'(bus.c_shield_out), 1);
    check_eq("t6_o_isr", 32'(bus.o_isr), 1);
    #2;
    reset = 0;
    #1;
    model_reset();
    compare_all("t6_async");
    check_eq("t6_c_shield_rst", 32'(bus.c_shield_out), 0);
    check_eq("t6_o_isr_rst", 32'(bus.o_isr), 0);
    check_eq("t6_if_rst", 32'(bus.IF_out), 0);
    bus.int_num = 3'd3;
    #1;
    check_eq("t6_vec_in_rst", 32'(bus.vec_out), 32'h0F6);
    step("t6_hold");
    reset = 1;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) bus.c_req = ~bus.c_req;
      if ($urandom_range(0, 2) == 0) bus.o_req = ~bus.o_req;
      bus.IF_set   = ($urandom_range(0, 7) == 0);
      bus.IF_clear = ($urandom_range(0, 7) == 0);
      bus.c_clear  = ($urandom_range(0, 5) == 0);
      bus.o_clear  = ($urandom_range(0, 5) == 0);
      bus.c_allow  = !bus.c_clear && ($urandom_range(0, 5) == 0);
      bus.o_allow  = !bus.o_clear && ($urandom_range(0, 5) == 0);
      bus.c_ban    = ($urandom_range(0, 7) == 0);
      bus.o_ban    = ($urandom_range(0, 7) == 0);
      bus.ovr_clr  = ($urandom_range(0, 9) == 0);
      bus.int_num  = 3'($urandom_range(0, 7));
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
